// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle RV32I sequencing
// controller. Holds the FSM state enum, the opcodes the controller
// implements, and the select/ALU/immediate encodings it drives onto the
// datapath muxes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: funct3/funct7b5 decode to an ALU operation.
// Ports:
//   i_funct3     instr[14:12]
//   i_funct7b5   instr[30]; selects sub only for R-type funct3 000
//   i_is_rtype   1 when decoding a register-register instruction
//   o_alu_control ALU operation (mc_pkg ALU_* encoding)
//   o_illegal    funct3 outside the supported set (000, 010, 110, 111); o_alu_control is add in that case
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_is_rtype,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_funct3)
            3'b000:  if (i_is_rtype && i_funct7b5) o_alu_control = ALU_SUB;
            3'b010:  o_alu_control = ALU_SLT;
            3'b110:  o_alu_control = ALU_OR;
            3'b111:  o_alu_control = ALU_AND;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle sequencing controller for the RV32I subset
// (lw, sw, R-type, I-type ALU, beq, jal) on a unified-memory datapath.
// Outputs decode combinationally from the state register (plus zero and
// mem_ready); imm_src decodes from op. Unimplemented opcodes or funct3
// values park the FSM in a sticky TRAP state that only reset leaves.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   op/funct3/funct7b5 fields from the instruction register
//   zero, mem_ready    ALU zero flag; memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//   alu_src_b, imm_src, reg_write, alu_control   datapath controls
//   trap               sticky illegal-instruction flag
//   cycle_cnt, instret_cnt  performance counters
// Build option: define MC_PERF_CNT_EN to implement the counters; without it
// both counter ports are constant 0.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic [2:0]       alu_control,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t     r_state;
    logic [2:0] w_alu_dec;
    logic       w_alu_illegal;
    logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write;

    mc_alu_dec u_alu_dec (
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_is_rtype    (r_state == S_EXECR),
        .o_alu_control (w_alu_dec),
        .o_illegal     (w_alu_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI:    r_state <= w_alu_illegal ? S_TRAP : S_ALUWB;
                S_JAL:      r_state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BEQ:      r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = ADR_PC;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        trap        = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = ADR_ALUOUT;
            S_MEMWB: begin
                result_src  = RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = ADR_ALUOUT;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_control = w_alu_dec;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = w_alu_dec;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_control = ALU_SUB;
                w_pc_write  = zero;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
            S_TRAP:     trap = 1'b1;
            default: ;
        endcase
    end

    // Reset parks the state in FETCH, where pc/ir enables follow mem_ready;
    // gate every write enable with reset so nothing commits while held.
    assign pc_write  = w_pc_write  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign imm_src   = imm_sel(op);

`ifdef MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;
    logic             w_retire;

    // Every path back to FETCH leaves through one of these states.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BEQ)   || (r_state == S_MEMWRITE && mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != S_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_retire) r_instret_cnt <= r_instret_cnt + CNT_ONE;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into its list of
// phases; a cycle walks that list, repeating memory phases while mem_ready
// is low. Expected outputs per phase come from the control table.
module tb_mc_ctrl_fsm;
    localparam int CNT_W = 32;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] op = IT;
    logic [2:0] funct3 = 3'b000;
    logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef enum int {P_F, P_D, P_ADR, P_RD, P_MWB, P_WR, P_EXR, P_EXI, P_WB, P_BR, P_J, P_TRAP} ph_t;
    typedef struct packed {
        logic pcw, adr, memw, irw, regw, trp;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
    } outs_t;

    ph_t   seq[$];
    int    idx, exp_cyc, exp_ret, n_pass, n_tot, ncyc;
    bit    done;
    outs_t obs, obs_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit f3_ok(input logic [2:0] f);
        return f inside {3'b000, 3'b010, 3'b110, 3'b111};
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f, input logic s, input bit isr);
        case (f)
            3'b000:  return (isr && s) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic outs_t expect_out(input ph_t p, input logic mr, input logic z);
        outs_t e = '0;
        e.imm = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
        case (p)
            P_F:    begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            P_D:    begin e.sa = 2'b01; e.sb = 2'b01; end
            P_ADR:  begin e.sa = 2'b10; e.sb = 2'b01; end
            P_RD:   e.adr = 1'b1;
            P_MWB:  begin e.res = 2'b01; e.regw = 1'b1; end
            P_WR:   begin e.adr = 1'b1; e.memw = 1'b1; end
            P_EXR:  begin e.sa = 2'b10; e.alu = alu_of(funct3, funct7b5, 1); end
            P_EXI:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_of(funct3, funct7b5, 0); end
            P_WB:   e.regw = 1'b1;
            P_BR:   begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
            P_J:    begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            P_TRAP: e.trp = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic load(input logic [6:0] o, input logic [2:0] f, input logic s);
        op = o; funct3 = f; funct7b5 = s;
        seq.delete(); seq.push_back(P_F); seq.push_back(P_D);
        case (o)
            LW: begin seq.push_back(P_ADR); seq.push_back(P_RD); seq.push_back(P_MWB); end
            SW: begin seq.push_back(P_ADR); seq.push_back(P_WR); end
            RT: begin seq.push_back(P_EXR); seq.push_back(f3_ok(f) ? P_WB : P_TRAP); end
            IT: begin seq.push_back(P_EXI); seq.push_back(f3_ok(f) ? P_WB : P_TRAP); end
            BQ: seq.push_back(P_BR);
            JL: begin seq.push_back(P_J); seq.push_back(P_WB); end
            default: seq.push_back(P_TRAP);
        endcase
        idx = 0;
    endtask

    // One clock: drive, compare against the phase table, advance the model.
    task automatic step(input logic mr, input logic z);
        ph_t p;
        outs_t e;
        mem_ready = mr; zero = z; done = 0;
        #1;
        p = seq[idx];
        e = expect_out(p, mr, z);
        obs = '{pcw: pc_write, adr: adr_src, memw: mem_write, irw: ir_write, regw: reg_write,
                trp: trap, res: result_src, sa: alu_src_a, sb: alu_src_b, imm: imm_src,
                alu: alu_control};
        chk("pc_write", obs.pcw, e.pcw);       chk("adr_src", obs.adr, e.adr);
        chk("mem_write", obs.memw, e.memw);    chk("ir_write", obs.irw, e.irw);
        chk("reg_write", obs.regw, e.regw);    chk("trap", obs.trp, e.trp);
        chk("result_src", obs.res, e.res);     chk("alu_src_a", obs.sa, e.sa);
        chk("alu_src_b", obs.sb, e.sb);        chk("imm_src", obs.imm, e.imm);
        if (!((p == P_EXR || p == P_EXI) && !f3_ok(funct3))) chk("alu_control", obs.alu, e.alu);
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, exp_cyc);  chk("instret_cnt", instret_cnt, exp_ret);
`else
        chk("cycle_cnt", cycle_cnt, 0);        chk("instret_cnt", instret_cnt, 0);
`endif
        @(posedge clk); #1;
        if (p != P_TRAP) exp_cyc++;
        if (!(p == P_TRAP || ((p == P_F || p == P_RD || p == P_WR) && !mr))) begin
            idx++;
            if (idx == seq.size()) begin exp_ret++; idx = 0; done = 1; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        #1;
        chk("rst_pc_write", pc_write, 0);   chk("rst_ir_write", ir_write, 0);
        chk("rst_mem_write", mem_write, 0); chk("rst_reg_write", reg_write, 0);
        chk("rst_trap", trap, 0);           chk("rst_adr_src", adr_src, 0);
        chk("rst_alu_src_a", alu_src_a, 2'b00);
        chk("rst_alu_src_b", alu_src_b, 2'b10);
        chk("rst_result_src", result_src, 2'b10);
        chk("rst_cycle_cnt", cycle_cnt, 0); chk("rst_instret_cnt", instret_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cyc = 0; exp_ret = 0;
        load(IT, 3'b000, 1'b0);
    endtask

    // Runs one instruction; mwait low mem_ready cycles in its data phase.
    task automatic exec_instr(input logic [6:0] o, input logic [2:0] f, input logic s,
                              input int mwait, input logic z);
        int waited = 0;
        logic mr;
        load(o, f, s);
        obs_q.delete(); ncyc = 0;
        for (int c = 0; c < 60; c++) begin
            if (seq[idx] == P_TRAP) return;
            mr = 1'b1;
            if ((seq[idx] == P_RD || seq[idx] == P_WR) && waited < mwait) begin
                mr = 1'b0; waited++;
            end
            step(mr, z);
            obs_q.push_back(obs); ncyc++;
            if (done) return;
        end
        chk("exec_timeout", 1, 0);
    endtask

    task automatic rand_load();
        int r = $urandom_range(0, 19);
        logic [2:0] f;
        logic [6:0] o;
        logic [6:0] bad[4] = '{7'h7F, 7'h37, 7'h17, 7'h00};
        logic [2:0] good[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        f = ($urandom_range(0, 9) == 0) ? 3'($urandom) : good[$urandom_range(0, 3)];
        o = (r < 4) ? LW : (r < 7) ? SW : (r < 11) ? RT : (r < 15) ? IT :
            (r < 17) ? BQ : (r < 19) ? JL : bad[$urandom_range(0, 3)];
        load(o, f, 1'($urandom));
    endtask

    initial begin
        int n;
        do_reset();

        exec_instr(RT, 3'b000, 1'b1, 0, 1'b0);   // sub
        chk("rsub_cycles", ncyc, 4);
        chk("rsub_alu", obs_q[2].alu, 3'b001);
        n = 0; foreach (obs_q[i]) n += obs_q[i].regw;
        chk("rsub_regw_cnt", n, 1);
        chk("rsub_regw_wb", obs_q[3].regw, 1);

        exec_instr(LW, 3'b010, 1'b0, 2, 1'b0);
        chk("lw_wait_cycles", ncyc, 7);
        chk("lw_adr_rd", {obs_q[3].adr, obs_q[4].adr, obs_q[5].adr}, 3'b111);
        chk("lw_wb_res", obs_q[6].res, 2'b01);
        chk("lw_wb_regw", obs_q[6].regw, 1);

        exec_instr(SW, 3'b010, 1'b0, 3, 1'b0);
        n = 0; foreach (obs_q[i]) n += obs_q[i].memw;
        chk("sw_memw_cnt", n, 4);
        chk("sw_memw_run", {obs_q[3].memw, obs_q[4].memw, obs_q[5].memw, obs_q[6].memw}, 4'hF);
        chk("sw_cycles", ncyc, 7);

        exec_instr(BQ, 3'b000, 1'b0, 0, 1'b1);
        chk("beq_t_cycles", ncyc, 3);  chk("beq_t_pcw", obs_q[2].pcw, 1);
        exec_instr(BQ, 3'b000, 1'b0, 0, 1'b0);
        chk("beq_nt_cycles", ncyc, 3); chk("beq_nt_pcw", obs_q[2].pcw, 0);
        exec_instr(JL, 3'b000, 1'b0, 0, 1'b0);
        chk("jal_cycles", ncyc, 4);    chk("jal_pcw", obs_q[2].pcw, 1);
        exec_instr(LW, 3'b010, 1'b0, 0, 1'b0);
        chk("lw_cycles", ncyc, 5);
        exec_instr(IT, 3'b110, 1'b1, 0, 1'b0);
        chk("ori_cycles", ncyc, 4);    chk("ori_alu", obs_q[2].alu, 3'b011);
        exec_instr(IT, 3'b000, 1'b1, 0, 1'b0);
        chk("addi_no_sub", obs_q[2].alu, 3'b000);

        // Reset in the middle of a stalled store drops mem_write at once.
        load(SW, 3'b010, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        mem_ready = 1'b0; #1;
        chk("mid_memw_before", mem_write, 1);
        do_reset();

        exec_instr(7'b1111111, 3'b000, 1'b0, 0, 1'b0);
        chk("trap_cycles_to", ncyc, 2);
        n = 0;
        repeat (100) begin step(1'($urandom), 1'($urandom)); n += obs.trp; end
        chk("trap_held", n, 100);
`ifdef MC_PERF_CNT_EN
        chk("trap_cyc_frozen", cycle_cnt, 2);
`else
        chk("trap_cyc_frozen", cycle_cnt, 0);
`endif
        chk("trap_ret_frozen", instret_cnt, 0);
        do_reset();
        step(1'b1, 1'b0);   // next phase after reset is FETCH

        do_reset();
        for (int i = 0; i < 10; i++) exec_instr(IT, 3'b000, 1'($urandom), 0, 1'b0);
        #1;
`ifdef MC_PERF_CNT_EN
        chk("perf_cycle", cycle_cnt, 40); chk("perf_instret", instret_cnt, 10);
`else
        chk("perf_cycle", cycle_cnt, 0);  chk("perf_instret", instret_cnt, 0);
`endif

        do_reset();
        rand_load();
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seq[idx] == P_TRAP && ++n > 3) begin
                do_reset(); rand_load(); n = 0;
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom));
                if (done) rand_load();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
